// File: rtl/llr_loader_pkg.sv
// rtl/llr_loader_pkg.sv - shared FSM state and error-code definitions for the LLR input loader
package llr_loader_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_LOAD,
        S_DONE
    } loader_state_t;

    localparam logic [1:0] ERR_NONE          = 2'b00;
    localparam logic [1:0] ERR_EARLY_TLAST   = 2'b01;
    localparam logic [1:0] ERR_MISSING_TLAST = 2'b10;

endpackage

// File: rtl/llr_sym_sat.sv
// rtl/llr_sym_sat.sv - maps the most-negative LLR code onto its symmetric neighbour
module llr_sym_sat #(
    parameter int LLR_WIDTH = 8
) (
    input  logic [LLR_WIDTH-1:0] llr_in,
    output logic [LLR_WIDTH-1:0] llr_out
);

    localparam logic [LLR_WIDTH-1:0] MOST_NEG = LLR_WIDTH'(1) << (LLR_WIDTH - 1);
    localparam logic [LLR_WIDTH-1:0] SYM_NEG  = MOST_NEG + LLR_WIDTH'(1);

    assign llr_out = (llr_in == MOST_NEG) ? SYM_NEG : llr_in;

endmodule

// File: rtl/llr_input_loader.sv
// rtl/llr_input_loader.sv - stream-to-BRAM LLR frame loader; LLR_SYM_SATURATE_EN enables symmetric lane saturation
module llr_input_loader
    import llr_loader_pkg::*;
#(
    parameter int                     FRAME_LEN       = 1024,
    parameter int                     LANES           = 4,
    parameter int                     LLR_WIDTH       = 8,
    parameter int                     STATE_WIDTH     = 10,
    parameter logic [STATE_WIDTH-1:0] INPUT_STATE     = 10'd2,
    parameter int                     RESET_WAIT_TIME = 20,
    localparam int                    BEATS           = FRAME_LEN / LANES,
    localparam int                    ADDR_WIDTH      = (BEATS > 1) ? $clog2(BEATS) : 1
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [STATE_WIDTH-1:0]        state,
    input  logic                          saxis_tvalid,
    input  logic                          saxis_tlast,
    input  logic [LANES*LLR_WIDTH-1:0]    saxis_tdata,
    output logic                          saxis_tready,
    output logic [ADDR_WIDTH-1:0]         bram_addr,
    output logic [LANES*LLR_WIDTH-1:0]    bram_wdata,
    output logic                          bram_en,
    output logic                          bram_we,
    output logic                          load_done,
    output logic                          error,
    output logic [1:0]                    error_code
);

    localparam int DATA_WIDTH = LANES * LLR_WIDTH;
    localparam int WAIT_WIDTH = (RESET_WAIT_TIME > 1) ? $clog2(RESET_WAIT_TIME) : 1;
    localparam logic [WAIT_WIDTH-1:0] WAIT_LAST = WAIT_WIDTH'(RESET_WAIT_TIME - 1);
    localparam logic [ADDR_WIDTH-1:0] BEAT_LAST = ADDR_WIDTH'(BEATS - 1);

    loader_state_t          cur_state;
    loader_state_t          next_state;
    logic [WAIT_WIDTH-1:0]  wait_cnt;
    logic [ADDR_WIDTH-1:0]  beat_cnt;
    logic                   done_q;
    logic                   error_q;
    logic [1:0]             error_code_q;
    logic                   in_state;
    logic                   accept;
    logic                   last_beat;
    logic [DATA_WIDTH-1:0]  sat_data;

    assign in_state  = (state == INPUT_STATE);
    assign accept    = (cur_state == S_LOAD) && saxis_tvalid;
    assign last_beat = (beat_cnt == BEAT_LAST);

`ifdef LLR_SYM_SATURATE_EN
    for (genvar i = 0; i < LANES; i++) begin : g_sat
        llr_sym_sat #(
            .LLR_WIDTH (LLR_WIDTH)
        ) u_sat (
            .llr_in  (saxis_tdata[i*LLR_WIDTH +: LLR_WIDTH]),
            .llr_out (sat_data[i*LLR_WIDTH +: LLR_WIDTH])
        );
    end
`else
    assign sat_data = saxis_tdata;
`endif

    always_comb begin
        next_state   = cur_state;
        saxis_tready = 1'b0;
        bram_en      = 1'b0;
        case (cur_state)
            S_IDLE: begin
                if (in_state) next_state = S_WAIT;
            end
            S_WAIT: begin
                bram_en = 1'b1;
                if (wait_cnt == WAIT_LAST) next_state = S_LOAD;
            end
            S_LOAD: begin
                saxis_tready = 1'b1;
                bram_en      = 1'b1;
                if (accept && (last_beat || saxis_tlast)) next_state = S_DONE;
            end
            S_DONE: begin
                next_state = S_DONE;
            end
            default: next_state = S_IDLE;
        endcase
        // Leaving the input phase overrides everything and restarts from idle
        if (!in_state) next_state = S_IDLE;
    end

    // Data is gated outside S_LOAD so the write bus reads zero while idle or in reset
    assign bram_we    = accept;
    assign bram_addr  = beat_cnt;
    assign bram_wdata = (cur_state == S_LOAD) ? sat_data : '0;
    assign load_done  = done_q;
    assign error      = error_q;
    assign error_code = error_code_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cur_state    <= S_IDLE;
            wait_cnt     <= '0;
            beat_cnt     <= '0;
            done_q       <= 1'b0;
            error_q      <= 1'b0;
            error_code_q <= ERR_NONE;
        end else begin
            cur_state <= next_state;
            done_q    <= 1'b0;
            case (cur_state)
                S_IDLE: begin
                    if (in_state) begin
                        wait_cnt     <= '0;
                        beat_cnt     <= '0;
                        error_q      <= 1'b0;
                        error_code_q <= ERR_NONE;
                    end
                end
                S_WAIT: begin
                    wait_cnt <= wait_cnt + WAIT_WIDTH'(1);
                end
                S_LOAD: begin
                    if (accept) begin
                        if (!last_beat) beat_cnt <= beat_cnt + ADDR_WIDTH'(1);
                        if (in_state) begin
                            if (last_beat) begin
                                done_q <= 1'b1;
                                if (!saxis_tlast) begin
                                    error_q      <= 1'b1;
                                    error_code_q <= ERR_MISSING_TLAST;
                                end
                            end else if (saxis_tlast) begin
                                error_q      <= 1'b1;
                                error_code_q <= ERR_EARLY_TLAST;
                            end
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_llr_input_loader.sv
// tb/tb_llr_input_loader.sv - directed self-checking bench for llr_input_loader
module tb_llr_input_loader;

    logic        clk = 1'b0;
    logic        reset;
    logic [9:0]  state;
    logic        saxis_tvalid;
    logic        saxis_tlast;
    logic [31:0] saxis_tdata;
    logic        saxis_tready;
    logic [7:0]  bram_addr;
    logic [31:0] bram_wdata;
    logic        bram_en;
    logic        bram_we;
    logic        load_done;
    logic        error;
    logic [1:0]  error_code;

    int total = 0;
    int bad   = 0;

    logic [31:0] mem [0:255];
    int          wr_count = 0;
    int          bad_wr   = 0;

    always #5 clk = ~clk;

    llr_input_loader #(
        .FRAME_LEN       (1024),
        .LANES           (4),
        .LLR_WIDTH       (8),
        .STATE_WIDTH     (10),
        .INPUT_STATE     (10'd2),
        .RESET_WAIT_TIME (20)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .state        (state),
        .saxis_tvalid (saxis_tvalid),
        .saxis_tlast  (saxis_tlast),
        .saxis_tdata  (saxis_tdata),
        .saxis_tready (saxis_tready),
        .bram_addr    (bram_addr),
        .bram_wdata   (bram_wdata),
        .bram_en      (bram_en),
        .bram_we      (bram_we),
        .load_done    (load_done),
        .error        (error),
        .error_code   (error_code)
    );

    always @(posedge clk) begin
        if (bram_en && bram_we) begin
            mem[bram_addr] <= bram_wdata;
            wr_count       <= wr_count + 1;
            if (!saxis_tvalid) bad_wr <= bad_wr + 1;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] bdata(input int k, input int mode);
        logic [31:0] d;
        for (int i = 0; i < 4; i++) begin
            case (mode)
                0:       d[i*8 +: 8] = 8'(4 * k + i);
                1:       d[i*8 +: 8] = 8'(k);
                default: d[i*8 +: 8] = 8'(k) ^ 8'hA5;
            endcase
        end
        return d;
    endfunction

    task automatic start_frame(input string tag);
        int n;
        saxis_tvalid = 1'b0;
        saxis_tlast  = 1'b0;
        state        = 10'd3;
        tick();
        state = 10'd2;
        tick();
        check({tag, "_wait_en"}, 64'(bram_en), 64'd1);
        check({tag, "_wait_rdy"}, 64'(saxis_tready), 64'd0);
        check({tag, "_entry_err"}, {62'd0, error_code}, 64'd0);
        n = 0;
        while (!saxis_tready && n < 100) begin
            tick();
            n++;
        end
        check({tag, "_wait_len"}, 64'(n), 64'd20);
    endtask

    task automatic stream(input string tag, input int first, input int last_k,
                          input int tlast_at, input int mode);
        int miss;
        miss = 0;
        for (int k = first; k <= last_k; k++) begin
            saxis_tdata  = bdata(k, mode);
            saxis_tvalid = 1'b1;
            saxis_tlast  = (k == tlast_at);
            #1;
            if (bram_we !== 1'b1 || bram_addr !== 8'(k) || bram_wdata !== bdata(k, mode)) miss++;
            tick();
        end
        saxis_tvalid = 1'b0;
        saxis_tlast  = 1'b0;
        check({tag, "_beats"}, 64'(miss), 64'd0);
    endtask

    initial begin
        int base;
        int k;
        int cyc;
        int idle_we;
        int mm;

        reset        = 1'b1;
        state        = 10'd0;
        saxis_tvalid = 1'b1;
        saxis_tlast  = 1'b1;
        saxis_tdata  = 32'hDEADBEEF;
        #2;
        tick();
        check("rst_tready", 64'(saxis_tready), 64'd0);
        check("rst_en", 64'(bram_en), 64'd0);
        check("rst_we", 64'(bram_we), 64'd0);
        check("rst_wdata", 64'(bram_wdata), 64'd0);
        check("rst_addr", 64'(bram_addr), 64'd0);
        check("rst_done", 64'(load_done), 64'd0);
        check("rst_err", {61'd0, error, error_code}, 64'd0);
        reset        = 1'b0;
        saxis_tvalid = 1'b0;
        saxis_tlast  = 1'b0;
        tick();

        // Good frame, tvalid held high
        start_frame("t1");
        base = wr_count;
        stream("t1", 0, 255, 255, 0);
        check("t1_done", 64'(load_done), 64'd1);
        check("t1_err", {61'd0, error, error_code}, 64'd0);
        check("t1_rdy", 64'(saxis_tready), 64'd0);
        check("t1_en", 64'(bram_en), 64'd0);
        check("t1_wr", 64'(wr_count - base), 64'd256);
        check("t1_mem0", 64'(mem[0]), 64'h03020100);
        check("t1_mem255", 64'(mem[255]), 64'hFFFEFDFC);
        tick();
        check("t1_done_pulse", 64'(load_done), 64'd0);
        check("t1_rdy_hold", 64'(saxis_tready), 64'd0);

        // Random tvalid gaps, beat index in every lane
        start_frame("t2");
        base    = wr_count;
        k       = 0;
        cyc     = 0;
        idle_we = 0;
        while (k < 256 && cyc < 5000) begin
            saxis_tvalid = 1'($urandom_range(0, 1));
            saxis_tdata  = bdata(k, 1);
            saxis_tlast  = (k == 255);
            #1;
            if (!saxis_tvalid && bram_we) idle_we++;
            tick();
            if (saxis_tvalid) k++;
            cyc++;
        end
        saxis_tvalid = 1'b0;
        saxis_tlast  = 1'b0;
        check("t2_beats", 64'(k), 64'd256);
        check("t2_idle_we", 64'(idle_we), 64'd0);
        check("t2_bad_wr", 64'(bad_wr), 64'd0);
        check("t2_done", 64'(load_done), 64'd1);
        check("t2_wr", 64'(wr_count - base), 64'd256);
        mm = 0;
        for (int j = 0; j < 256; j++) if (mem[j] !== bdata(j, 1)) mm++;
        check("t2_mem", 64'(mm), 64'd0);

        // Early tlast on beat 100
        start_frame("t3");
        base = wr_count;
        stream("t3", 0, 100, 100, 2);
        check("t3_err", 64'(error), 64'd1);
        check("t3_code", 64'(error_code), 64'd1);
        check("t3_done", 64'(load_done), 64'd0);
        check("t3_rdy", 64'(saxis_tready), 64'd0);
        check("t3_mem100", 64'(mem[100]), 64'hC1C1C1C1);
        check("t3_wr", 64'(wr_count - base), 64'd101);
        repeat (5) tick();
        check("t3_rdy_hold", 64'(saxis_tready), 64'd0);
        check("t3_err_hold", {61'd0, error, error_code}, 64'd5);

        // Error holds in idle, clears on re-entry; missing tlast
        state = 10'd3;
        tick();
        check("t4_idle_err", {61'd0, error, error_code}, 64'd5);
        start_frame("t4");
        stream("t4", 0, 255, -1, 2);
        check("t4_done", 64'(load_done), 64'd1);
        check("t4_err", 64'(error), 64'd1);
        check("t4_code", 64'(error_code), 64'd2);

        // Leave input state at beat 50, re-enter, then async reset at beat 30
        start_frame("t5");
        stream("t5a", 0, 49, -1, 0);
        state = 10'd3;
        tick();
        check("t5_exit_rdy", 64'(saxis_tready), 64'd0);
        check("t5_exit_en", 64'(bram_en), 64'd0);
        start_frame("t5r");
        saxis_tdata  = bdata(0, 1);
        saxis_tvalid = 1'b1;
        #1;
        check("t5_restart_addr", 64'(bram_addr), 64'd0);
        check("t5_restart_we", 64'(bram_we), 64'd1);
        tick();
        stream("t5b", 1, 29, -1, 1);
        saxis_tdata  = bdata(30, 1);
        saxis_tvalid = 1'b1;
        #1;
        check("t5_pre_rst_we", 64'(bram_we), 64'd1);
        reset = 1'b1;
        #1;
        check("t5_rst_outs", {bram_wdata, bram_addr, saxis_tready, bram_en, bram_we,
                              load_done, error, error_code}, 64'd0);
        #3;
        reset        = 1'b0;
        saxis_tvalid = 1'b0;
        tick();

        // Lane saturation of the most-negative code
        start_frame("t6");
        saxis_tdata  = 32'h007F8080;
        saxis_tvalid = 1'b1;
        #1;
`ifdef LLR_SYM_SATURATE_EN
        check("t6_sat_a", 64'(bram_wdata), 64'h007F8181);
`else
        check("t6_sat_a", 64'(bram_wdata), 64'h007F8080);
`endif
        tick();
        saxis_tdata = 32'h8000807F;
        #1;
`ifdef LLR_SYM_SATURATE_EN
        check("t6_sat_b", 64'(bram_wdata), 64'h8100817F);
`else
        check("t6_sat_b", 64'(bram_wdata), 64'h8000807F);
`endif
        check("t6_addr", 64'(bram_addr), 64'd1);
        tick();
        saxis_tvalid = 1'b0;
        state        = 10'd0;
        tick();
        check("t6_exit_rdy", 64'(saxis_tready), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/llr_input_loader.md
Name: llr_input_loader

Overview:
Next-generation AXI-Stream LLR loader for the polar decoder. It accepts LANES packed LLRs per beat and writes one beat per BRAM word. A frame-level FSM adds a per-entry RAM-reset wait, a frame-complete pulse, and classified, sticky framing errors. It sits between the DMA stream and the LLR init BRAM, and runs while the top-level state equals INPUT_STATE.

Parameters:
- FRAME_LEN, 1024, LLRs per frame; must be a multiple of LANES.
- LANES, 4, LLRs per beat; must be ≥1.
- LLR_WIDTH, 8, bits per LLR.
- BEATS, FRAME_LEN/LANES (derived localparam), beats per frame.
- ADDR_WIDTH, $clog2(BEATS) (derived; min 1), BRAM word address width.
- STATE_WIDTH, 10, width of the top-level state bus.
- INPUT_STATE, 10'd2, state code that enables loading.
- RESET_WAIT_TIME, 20, cycles to wait for BRAM reset on each entry; must be ≥1.

Ports:
- clk  in  1  clock
- reset  in  1  reset, asynchronous, active-high
- state  in  STATE_WIDTH  top-level decoder state
- saxis_tvalid  in  1  stream valid
- saxis_tlast  in  1  end of frame
- saxis_tdata  in  LANES*LLR_WIDTH  packed LLRs; lane i in bits [i*LLR_WIDTH +: LLR_WIDTH]; lane 0 is the lowest LLR index
- saxis_tready  out  1  stream ready
- bram_addr  out  ADDR_WIDTH  write address (beat index)
- bram_wdata  out  LANES*LLR_WIDTH  write data
- bram_en  out  1  port-A enable
- bram_we  out  1  write enable
- load_done  out  1  one-cycle pulse: frame fully loaded
- error  out  1  sticky framing error
- error_code  out  2  01 = early tlast, 10 = missing tlast, 00 = none

Behaviour:
- Reset (async) forces FSM = S_IDLE and clears all counters.
  - All outputs are 0 during reset, including bram_wdata.
- FSM states: S_IDLE, S_WAIT, S_LOAD, S_DONE.
- Exit rule: from any state, if state != INPUT_STATE, go to S_IDLE next cycle.
  - error and error_code hold their values in S_IDLE.
- S_IDLE → S_WAIT when state == INPUT_STATE.
  - On this transition: wait_cnt = 0, beat_cnt = 0, error = 0, error_code = 00.
- S_WAIT: bram_en = 1, tready = 0.
  - wait_cnt increments each cycle.
  - Go to S_LOAD when wait_cnt == RESET_WAIT_TIME-1, so S_WAIT lasts exactly RESET_WAIT_TIME cycles.
- S_LOAD: tready = 1, bram_en = 1.
  - Accept = tvalid & tready.
  - bram_we = accept, combinational in the same cycle (zero latency).
  - bram_addr = beat_cnt; bram_wdata = tdata (after optional saturation).
  - beat_cnt increments on each accept.
- Accept with beat_cnt == BEATS-1:
  - With tlast: go to S_DONE, load_done = 1 on the next cycle.
  - Without tlast: go to S_DONE, load_done pulses, error = 1, error_code = 10.
- Accept with tlast and beat_cnt < BEATS-1 (early tlast):
  - The beat is still written.
  - Go to S_DONE, error = 1, error_code = 01, no load_done.
- S_DONE: tready = 0, bram_en = 0, we = 0.
  - Holds until state leaves INPUT_STATE.
  - load_done is high only in the first cycle of S_DONE, and only for a good or missing-tlast completion.
- If tvalid drops mid-frame, nothing happens: no write, counter holds.
- beat_cnt never wraps within a frame, because the FSM leaves S_LOAD at BEATS-1.
- Re-entering INPUT_STATE restarts the full wait and the frame.
- A reset mid-frame aborts the frame; the partially written BRAM contents are undefined to consumers.

Optional Feature:
- Macro: LLR_SYM_SATURATE_EN.
- Defined: each lane equal to the most-negative value (-2^(LLR_WIDTH-1)) is replaced by -(2^(LLR_WIDTH-1)-1) before writing, giving a symmetric LLR range. This is combinational and adds no latency.
- Undefined: tdata passes through bit-exact.

Decomposition:
- Package llr_loader_pkg:
  - typedef enum loader_state_t {S_IDLE, S_WAIT, S_LOAD, S_DONE}
  - constants ERR_NONE = 2'b00, ERR_EARLY_TLAST = 2'b01, ERR_MISSING_TLAST = 2'b10
- Sub-module llr_sym_sat (one LLR_WIDTH lane):
  - Instantiated LANES times in a generate loop under LLR_SYM_SATURATE_EN.

Test Plan:
- FRAME_LEN=1024, LANES=4; state=2, tvalid held high → tready rises after exactly 20 cycles; 256 writes at addr 0..255; tlast on beat 255 → load_done pulses 1 cycle, error=0, tready=0 afterwards.
- Same setup, tvalid toggled randomly and tdata = beat index in every lane → BRAM word k holds k in all lanes; no write occurs while tvalid=0.
- tlast asserted on beat 100 → beat 100 is written; error=1, error_code=01; no load_done; tready=0 until state changes.
- tlast never asserted → after beat 255: load_done pulses, error=1, error_code=10.
- state changed from 2 to 3 at beat 50, then back to 2 → the 20-cycle wait repeats, writes restart at addr 0, error cleared; async reset asserted at beat 30 → all outputs 0 immediately.
- LLR_SYM_SATURATE_EN defined, lane value 8'h80 → written as 8'h81; 8'h7F and 8'h00 unchanged. With the macro undefined, 8'h80 is written unchanged.
